// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared state, fail-code and sizing definitions for mem_write_checker
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_DATA    = 2'd1;
  localparam logic [1:0] FAIL_ADR     = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  // Index width that stays legal for a single-entry table.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/checker_fifo.sv
// rtl/checker_fifo.sv - DEPTH x WIDTH synchronous FIFO holding the expected writes
module checker_fifo
  import checker_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - in-order expected-write checker; timeout gated by MEM_WRITE_CHECKER_TIMEOUT_EN
module mem_write_checker
  import checker_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int STRICT  = 1,
  parameter int TIMEOUT = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             exp_valid,
  output logic                             exp_ready,
  input  logic [AW-1:0]                    exp_adr,
  input  logic [DW-1:0]                    exp_data,
  input  logic                             start,
  input  logic                             mem_write,
  input  logic [AW-1:0]                    adr,
  input  logic [DW-1:0]                    write_data,
  output logic                             done,
  output logic                             pass,
  output logic [1:0]                       fail_code,
  output logic [idx_width(DEPTH)-1:0]      fail_index,
  output logic [$clog2(DEPTH+1)-1:0]       match_count
);

  localparam int IW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t          state;
  logic            push;
  logic            pop;
  logic [AW+DW-1:0] head;
  logic [AW-1:0]   head_adr;
  logic [DW-1:0]   head_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            adr_hit;
  logic            match;
  logic            timeout_hit;

  assign exp_ready = (state == IDLE) && !fifo_full;
  assign push      = exp_valid && exp_ready;
  assign head_adr  = head[AW+DW-1:DW];
  assign head_data = head[DW-1:0];

  // Unknown bits make these compares non-true, so X/Z never counts as a match.
  assign adr_hit = mem_write && (adr == head_adr);
  assign match   = (state == ARMED) && adr_hit && (write_data == head_data);
  assign pop     = match;

  checker_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data ({exp_adr, exp_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;

  // Fires on the edge where the counter would reach TIMEOUT.
  assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // Cycles since arming or since the last accepted match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE && start) begin
      tmo_cnt <= '0;
    end else if (state == ARMED) begin
      if (match) tmo_cnt <= '0;
      else       tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  // Without the counter a timeout can never be raised.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Checker FSM with registered verdict outputs; a match outranks a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      fail_index  <= '0;
      match_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (fifo_empty && !push) begin
              state <= PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (match) begin
            match_count <= match_count + CW'(1);
            if (fifo_count == CW'(1)) begin
              state <= PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end else if (adr_hit) begin
            state      <= FAIL;
            done       <= 1'b1;
            fail_code  <= FAIL_DATA;
            fail_index <= match_count[IW-1:0];
          end else if (mem_write && (STRICT != 0)) begin
            state      <= FAIL;
            done       <= 1'b1;
            fail_code  <= FAIL_ADR;
            fail_index <= match_count[IW-1:0];
          end else if (timeout_hit) begin
            state      <= FAIL;
            done       <= 1'b1;
            fail_code  <= FAIL_TIMEOUT;
            fail_index <= match_count[IW-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - scoreboard bench for mem_write_checker (strict and lenient instances)
module tb_mem_write_checker;

  logic        clk;
  logic        reset;
  logic        exp_valid;
  logic [31:0] exp_adr;
  logic [31:0] exp_data;
  logic        start;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] write_data;

  logic        exp_ready_s, done_s, pass_s;
  logic [1:0]  fail_code_s;
  logic [2:0]  fail_index_s;
  logic [3:0]  match_count_s;
  logic        exp_ready_n, done_n, pass_n;
  logic [1:0]  fail_code_n;
  logic [2:0]  fail_index_n;
  logic [3:0]  match_count_n;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic       done;
    logic       pass;
    logic [1:0] code;
    logic [2:0] idx;
    logic [3:0] mc;
  } verdict_t;

  verdict_t sb[$];

  mem_write_checker #(.AW(32), .DW(32), .DEPTH(8), .STRICT(1), .TIMEOUT(20)) dut_s (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_ready(exp_ready_s),
    .exp_adr(exp_adr), .exp_data(exp_data), .start(start), .mem_write(mem_write),
    .adr(adr), .write_data(write_data), .done(done_s), .pass(pass_s),
    .fail_code(fail_code_s), .fail_index(fail_index_s), .match_count(match_count_s)
  );

  mem_write_checker #(.AW(32), .DW(32), .DEPTH(8), .STRICT(0), .TIMEOUT(20)) dut_n (
    .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_ready(exp_ready_n),
    .exp_adr(exp_adr), .exp_data(exp_data), .start(start), .mem_write(mem_write),
    .adr(adr), .write_data(write_data), .done(done_n), .pass(pass_n),
    .fail_code(fail_code_n), .fail_index(fail_index_n), .match_count(match_count_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input logic d, input logic p, input logic [1:0] c,
                          input logic [2:0] i, input logic [3:0] m);
    verdict_t v;
    v.done = d; v.pass = p; v.code = c; v.idx = i; v.mc = m;
    sb.push_back(v);
  endtask

  task automatic compare_v(input string tag, input bit use_n);
    verdict_t v;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    v = sb.pop_front();
    if (use_n) begin
      check_val({tag, "_done"}, {31'd0, done_n}, {31'd0, v.done});
      check_val({tag, "_pass"}, {31'd0, pass_n}, {31'd0, v.pass});
      check_val({tag, "_code"}, {30'd0, fail_code_n}, {30'd0, v.code});
      check_val({tag, "_idx"},  {29'd0, fail_index_n}, {29'd0, v.idx});
      check_val({tag, "_mc"},   {28'd0, match_count_n}, {28'd0, v.mc});
    end else begin
      check_val({tag, "_done"}, {31'd0, done_s}, {31'd0, v.done});
      check_val({tag, "_pass"}, {31'd0, pass_s}, {31'd0, v.pass});
      check_val({tag, "_code"}, {30'd0, fail_code_s}, {30'd0, v.code});
      check_val({tag, "_idx"},  {29'd0, fail_index_s}, {29'd0, v.idx});
      check_val({tag, "_mc"},   {28'd0, match_count_s}, {28'd0, v.mc});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    exp_valid = 1'b1; exp_adr = a; exp_data = d;
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = 1'b1; adr = a; write_data = d;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_done;
    n_compared = 0; n_mismatched = 0;
    reset = 1'b0; exp_valid = 1'b0; exp_adr = '0; exp_data = '0;
    start = 1'b0; mem_write = 1'b0; adr = '0; write_data = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_ready", {31'd0, exp_ready_s}, 32'd1);
    expect_v(0, 0, 2'd0, 3'd0, 4'd0);
    compare_v("rst", 0);
    reset = 1'b1;
    @(negedge clk);

    // Single entry, matching write: verdict one cycle after the write
    load(32'h5C, 32'd7);
    arm();
    check_val("t1_armed_ready", {31'd0, exp_ready_s}, 32'd0);
    check_val("t1_not_done", {31'd0, done_s}, 32'd0);
    expect_v(1, 1, 2'd0, 3'd0, 4'd1);
    wr(32'h5C, 32'd7);
    compare_v("t1_pass", 0);

    // Data mismatch
    do_reset();
    load(32'h5C, 32'd7);
    arm();
    expect_v(1, 0, 2'd1, 3'd0, 4'd0);
    wr(32'h5C, 32'd8);
    compare_v("t2_data", 0);

    // Strict address mismatch on second entry
    do_reset();
    load(32'h60, 32'd1);
    load(32'h64, 32'd2);
    arm();
    wr(32'h60, 32'd1);
    check_val("t3_mc_mid", {28'd0, match_count_s}, 32'd1);
    expect_v(1, 0, 2'd2, 3'd1, 4'd1);
    wr(32'h68, 32'd2);
    compare_v("t3_adr", 0);

    // Lenient instance ignores stray write, back-to-back writes
    do_reset();
    load(32'h60, 32'd1);
    load(32'h64, 32'd2);
    arm();
    expect_v(1, 1, 2'd0, 3'd0, 4'd2);
    @(negedge clk);
    mem_write = 1'b1; adr = 32'h60; write_data = 32'd1;
    @(negedge clk);
    adr = 32'h70; write_data = 32'd9;
    @(negedge clk);
    adr = 32'h64; write_data = 32'd2;
    @(negedge clk);
    mem_write = 1'b0;
    compare_v("t4_lenient", 1);

    // Timeout
    do_reset();
    load(32'h80, 32'd5);
    arm();
    first_done = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done_s && first_done < 0) first_done = k;
    end
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    check_val("t5_tmo_cycle", first_done, 32'd20);
    expect_v(1, 0, 2'd3, 3'd0, 4'd0);
`else
    check_val("t5_tmo_cycle", first_done, 32'hFFFF_FFFF);
    check_val("t5_still_armed", {31'd0, exp_ready_s}, 32'd0);
    expect_v(0, 0, 2'd0, 3'd0, 4'd0);
`endif
    compare_v("t5_tmo", 0);

    // Start on an empty table passes immediately
    do_reset();
    expect_v(1, 1, 2'd0, 3'd0, 4'd0);
    arm();
    compare_v("t6_empty", 0);

    // Start and exp_valid on the same edge: entry is part of the armed table
    do_reset();
    @(negedge clk);
    exp_valid = 1'b1; exp_adr = 32'h90; exp_data = 32'd3; start = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0; start = 1'b0;
    check_val("t7_not_done", {31'd0, done_s}, 32'd0);
    expect_v(1, 1, 2'd0, 3'd0, 4'd1);
    wr(32'h90, 32'd3);
    compare_v("t7_same_edge", 0);

    // Full table, then asynchronous reset mid-ARMED
    do_reset();
    for (int i = 0; i < 8; i++) begin
      load(32'h100 + 32'(i * 4), 32'(i + 10));
      if (i == 6) check_val("t8_ready_7", {31'd0, exp_ready_s}, 32'd1);
    end
    check_val("t8_ready_full", {31'd0, exp_ready_s}, 32'd0);
    arm();
    wr(32'h100, 32'd10);
    check_val("t8_mc1", {28'd0, match_count_s}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("t8_rst_ready", {31'd0, exp_ready_s}, 32'd1);
    expect_v(0, 0, 2'd0, 3'd0, 4'd0);
    compare_v("t8_rst", 0);
    @(negedge clk);
    reset = 1'b1;
    expect_v(1, 1, 2'd0, 3'd0, 4'd0);
    arm();
    compare_v("t8_flushed", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
